// File: rtl/mlp_param_loader_if.sv
// Word-stream handshake between the parameter source and the MLP loader.
// The master drives valid/data/last and the slave answers with ready.
interface mlp_param_loader_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/mlp_param_loader.sv
// mlp_param_loader: unpacks a serial stream of Q(QM).(QN) words into the
// bias/weight arrays and the input vector of the MLP core, then pulses the
// core start strobes for one cycle after a complete, well-formed frame.
// Frame order: per layer, per neuron: bias, then N weights; then N x words.
// Optional feature macro: MLP_LOADER_CHECKSUM_EN appends a mod-2^W sum word
// that must match the running sum of the frame before the strobes fire.
module mlp_param_loader #(
  parameter int M  = 3,
  parameter int N  = 3,
  parameter int QM = 3,
  parameter int QN = 5
) (
  input  logic                                    clk,
  input  logic                                    nrst,
  input  logic                                    start,
  mlp_param_loader_if.slave                       s_in,
  output logic [N-1:0][QM+QN-1:0]                 x,
  output logic [M-2:0][N-1:0][N-1:0][QM+QN-1:0]   w,
  output logic [M-2:0][N-1:0][QM+QN-1:0]          b,
  output logic                                    init,
  output logic                                    initial_flag,
  output logic                                    weight_flag,
  output logic                                    busy,
  output logic                                    err
);

  localparam int W  = QM + QN;
  localparam int L  = M - 1;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(N + 1);

  localparam logic [LW-1:0] L_LAST = LW'(L - 1);
  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);
  localparam logic [JW-1:0] J_ONE  = JW'(1);
  localparam logic [KW-1:0] K_LAST = KW'(N);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIRE = 2'd2
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // Frame position: layer, neuron, slot (0 = bias, 1..N = weight), x index.
  logic [LW-1:0] l_r;
  logic [JW-1:0] j_r;
  logic [KW-1:0] k_r;
  logic [JW-1:0] i_r;
  logic          phase_r;       // 0 = weight/bias section, 1 = x section

  logic [N-1:0][W-1:0]               x_r;
  logic [L-1:0][N-1:0][N-1:0][W-1:0] w_r;
  logic [L-1:0][N-1:0][W-1:0]        b_r;

  logic in_ready_r;
  logic busy_r;
  logic err_r;
  logic fire_r;

  logic          hs_s;
  logic          is_final_s;
  logic          sum_bad_s;
  logic          frame_err_s;
  logic          accept_s;
  logic          store_s;
  logic          start_acc_s;
  logic [JW-1:0] widx_s;

  logic in_ready_nx_s;
  logic busy_nx_s;
  logic fire_nx_s;
  logic err_nx_s;
  logic wr_b_s;
  logic wr_w_s;
  logic wr_x_s;

  assign hs_s        = in_ready_r & s_in.in_valid;
  assign start_acc_s = (state_r == S_IDLE) & start;
  assign widx_s      = JW'(k_r - K_ONE);

`ifdef MLP_LOADER_CHECKSUM_EN
  logic [W-1:0] sum_r;
  logic         sum_phase_r;    // next word is the checksum word

  assign is_final_s = sum_phase_r;
  assign sum_bad_s  = (sum_r != s_in.in_data);
  assign store_s    = accept_s & ~sum_phase_r;

  // Running mod-2^W sum of the stored words and checksum-slot tracking.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sum_r       <= {W{1'b0}};
      sum_phase_r <= 1'b0;
    end else if (start_acc_s) begin
      sum_r       <= {W{1'b0}};
      sum_phase_r <= 1'b0;
    end else if (store_s) begin
      sum_r       <= sum_r + s_in.in_data;
      sum_phase_r <= phase_r & (i_r == J_LAST);
    end else begin
      sum_r       <= sum_r;
      sum_phase_r <= sum_phase_r;
    end
  end
`else
  assign is_final_s = phase_r & (i_r == J_LAST);
  assign sum_bad_s  = 1'b0;
  assign store_s    = accept_s;
`endif

  // A word is bad if in_last disagrees with the frame position, or if the
  // closing word fails the checksum; bad words are never stored.
  assign frame_err_s = hs_s & ((s_in.in_last != is_final_s) | (is_final_s & sum_bad_s));
  assign accept_s    = hs_s & ~frame_err_s;

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_LOAD;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (frame_err_s) begin
          next_state_s = S_IDLE;
        end else if (accept_s && is_final_s) begin
          next_state_s = S_FIRE;
        end else begin
          next_state_s = S_LOAD;
        end
      end
      S_FIRE: begin
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // FSM output decode: next values of the registered outputs and write enables.
  always_comb begin
    in_ready_nx_s = 1'b0;
    busy_nx_s     = 1'b0;
    fire_nx_s     = 1'b0;
    err_nx_s      = err_r;
    wr_b_s        = 1'b0;
    wr_w_s        = 1'b0;
    wr_x_s        = 1'b0;
    case (next_state_s)
      S_LOAD: begin
        in_ready_nx_s = 1'b1;
        busy_nx_s     = 1'b1;
      end
      S_FIRE: begin
        busy_nx_s = 1'b1;
        fire_nx_s = 1'b1;
      end
      default: begin
        in_ready_nx_s = 1'b0;
        busy_nx_s     = 1'b0;
      end
    endcase
    if (start_acc_s) begin
      err_nx_s = 1'b0;
    end else if (frame_err_s) begin
      err_nx_s = 1'b1;
    end else begin
      err_nx_s = err_r;
    end
    if (store_s) begin
      wr_b_s = ~phase_r & (k_r == {KW{1'b0}});
      wr_w_s = ~phase_r & (k_r != {KW{1'b0}});
      wr_x_s = phase_r;
    end else begin
      wr_b_s = 1'b0;
      wr_w_s = 1'b0;
      wr_x_s = 1'b0;
    end
  end

  // Registered handshake, status and strobe outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      fire_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      in_ready_r <= in_ready_nx_s;
      busy_r     <= busy_nx_s;
      fire_r     <= fire_nx_s;
      err_r      <= err_nx_s;
    end
  end

  // Frame position counters: slot carries into neuron, neuron into layer,
  // layer carry-out switches to the x section.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      l_r     <= {LW{1'b0}};
      j_r     <= {JW{1'b0}};
      k_r     <= {KW{1'b0}};
      i_r     <= {JW{1'b0}};
      phase_r <= 1'b0;
    end else if (start_acc_s) begin
      l_r     <= {LW{1'b0}};
      j_r     <= {JW{1'b0}};
      k_r     <= {KW{1'b0}};
      i_r     <= {JW{1'b0}};
      phase_r <= 1'b0;
    end else if (store_s && !phase_r) begin
      if (k_r == K_LAST) begin
        k_r <= {KW{1'b0}};
        if (j_r == J_LAST) begin
          j_r <= {JW{1'b0}};
          if (l_r == L_LAST) begin
            l_r     <= {LW{1'b0}};
            phase_r <= 1'b1;
          end else begin
            l_r <= l_r + L_ONE;
          end
        end else begin
          j_r <= j_r + J_ONE;
        end
      end else begin
        k_r <= k_r + K_ONE;
      end
    end else if (store_s && phase_r) begin
      if (i_r == J_LAST) begin
        i_r <= i_r;
      end else begin
        i_r <= i_r + J_ONE;
      end
    end else begin
      l_r     <= l_r;
      j_r     <= j_r;
      k_r     <= k_r;
      i_r     <= i_r;
      phase_r <= phase_r;
    end
  end

  // Parameter storage: words are written bit-exact to the addressed slot.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_r <= {(N * W){1'b0}};
      w_r <= {(L * N * N * W){1'b0}};
      b_r <= {(L * N * W){1'b0}};
    end else if (wr_b_s) begin
      b_r[l_r][j_r] <= s_in.in_data;
    end else if (wr_w_s) begin
      w_r[l_r][j_r][widx_s] <= s_in.in_data;
    end else if (wr_x_s) begin
      x_r[i_r] <= s_in.in_data;
    end else begin
      x_r <= x_r;
      w_r <= w_r;
      b_r <= b_r;
    end
  end

  assign s_in.in_ready = in_ready_r;
  assign x             = x_r;
  assign w             = w_r;
  assign b             = b_r;
  assign init          = fire_r;
  assign initial_flag  = fire_r;
  assign weight_flag   = fire_r;
  assign busy          = busy_r;
  assign err           = err_r;

endmodule
